// File: rtl/demux4_stream.sv
// demux4_stream: routes one valid/ready stream to one of four registered output channels, sel locked per packet
module demux4_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_last,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic               pkt_active,
  output logic [1:0]         cur_sel
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state, state_nx;
  logic [1:0] route, sel_nx;
  logic accept;
  assign pkt_active = state == PKT;
  assign route = state == IDLE ? in_sel : cur_sel;
  assign in_ready = !out_valid[route] | out_ready[route];
  assign accept = in_valid & in_ready;
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
    cur_sel <= rst ? 2'd0 : sel_nx;
  end
  always_comb begin
    state_nx = state;
    sel_nx = cur_sel;
    if (accept && state == IDLE && !in_last) begin
      state_nx = PKT;
      sel_nx = in_sel;
    end
    if (accept && state == PKT && in_last) state_nx = IDLE;
  end
  for (genvar k = 0; k < 4; k++) begin : g_ch
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid[k] <= 1'b0;
        out_data[k*WIDTH +: WIDTH] <= '0;
        out_last[k] <= 1'b0;
      end else if (accept && route == 2'(k)) begin
        out_valid[k] <= 1'b1;
        out_data[k*WIDTH +: WIDTH] <= in_data;
        out_last[k] <= in_last;
      end else if (out_ready[k]) begin
        out_valid[k] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed scenario tasks checking routing, packet locking, backpressure and reset
module tb_demux4_stream;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] in_data = 0;
  logic [1:0] in_sel = 0;
  logic in_last = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [31:0] out_data;
  logic [3:0] out_last, out_valid;
  logic [3:0] out_ready = 0;
  logic pkt_active;
  logic [1:0] cur_sel;
  int total = 0;
  int passed = 0;

  demux4_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .pkt_active(pkt_active), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic l);
    in_valid = 1;
    in_sel = s;
    in_data = d;
    in_last = l;
  endtask

  task automatic test_reset();
    rst = 1;
    out_ready = 4'b0000;
    drive(2'd2, 8'hAA, 1'b1);
    step();
    step();
    total++; if (out_valid !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", out_valid); else passed++;
    total++; if (pkt_active !== 1'b0) $display("FAIL reset_pkt got=%b exp=0", pkt_active); else passed++;
    total++; if (cur_sel !== 2'd0) $display("FAIL reset_cur_sel got=%0d exp=0", cur_sel); else passed++;
    total++; if (out_data !== 32'h0 || out_last !== 4'b0) $display("FAIL reset_data got=%h/%b exp=0/0", out_data, out_last); else passed++;
    in_valid = 0;
    rst = 0;
    step();
    total++; if (out_valid !== 4'b0000) $display("FAIL reset_no_accept got=%b exp=0000", out_valid); else passed++;
  endtask

  task automatic test_single_beats();
    logic [7:0] d [4] = '{8'd1, 8'd13, 8'd25, 8'd33};
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), d[i], 1'b1);
      step();
      total++; if (out_valid !== 4'(1 << i)) $display("FAIL single_valid ch%0d got=%b exp=%b", i, out_valid, 4'(1 << i)); else passed++;
      total++; if (out_data[i*8 +: 8] !== d[i] || out_last[i] !== 1'b1) $display("FAIL single_data ch%0d got=%0d/%b exp=%0d/1", i, out_data[i*8 +: 8], out_last[i], d[i]); else passed++;
      total++; if (pkt_active !== 1'b0) $display("FAIL single_pkt ch%0d got=%b exp=0", i, pkt_active); else passed++;
    end
    in_valid = 0;
    step();
    total++; if (out_valid !== 4'b0000) $display("FAIL single_drain got=%b exp=0000", out_valid); else passed++;
  endtask

  task automatic test_packet_lock();
    drive(2'd2, 8'd5, 1'b0);
    step();
    total++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'd5 || out_last[2] !== 1'b0) $display("FAIL lock_b1 got=%b/%0d/%b exp=0100/5/0", out_valid, out_data[23:16], out_last[2]); else passed++;
    total++; if (pkt_active !== 1'b1 || cur_sel !== 2'd2) $display("FAIL lock_pkt1 got=%b/%0d exp=1/2", pkt_active, cur_sel); else passed++;
    drive(2'd0, 8'd6, 1'b0);
    step();
    total++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'd6 || out_last[2] !== 1'b0) $display("FAIL lock_b2 got=%b/%0d/%b exp=0100/6/0", out_valid, out_data[23:16], out_last[2]); else passed++;
    total++; if (pkt_active !== 1'b1) $display("FAIL lock_pkt2 got=%b exp=1", pkt_active); else passed++;
    drive(2'd0, 8'd7, 1'b1);
    step();
    total++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'd7 || out_last[2] !== 1'b1) $display("FAIL lock_b3 got=%b/%0d/%b exp=0100/7/1", out_valid, out_data[23:16], out_last[2]); else passed++;
    total++; if (pkt_active !== 1'b0) $display("FAIL lock_pkt3 got=%b exp=0", pkt_active); else passed++;
    in_valid = 0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    drive(2'd1, 8'd13, 1'b1);
    step();
    total++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'd13) $display("FAIL bp_first got=%b/%0d exp=0010/13", out_valid, out_data[15:8]); else passed++;
    drive(2'd3, 8'd33, 1'b1);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_other_ready got=%b exp=1", in_ready); else passed++;
    step();
    total++; if (out_valid !== 4'b1010 || out_data[31:24] !== 8'd33 || out_data[15:8] !== 8'd13) $display("FAIL bp_other got=%b/%0d/%0d exp=1010/33/13", out_valid, out_data[31:24], out_data[15:8]); else passed++;
    drive(2'd1, 8'd14, 1'b1);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_stall_ready got=%b exp=0", in_ready); else passed++;
    step();
    total++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'd13) $display("FAIL bp_held got=%b/%0d exp=0010/13", out_valid, out_data[15:8]); else passed++;
    out_ready = 4'b1111;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else passed++;
    step();
    total++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'd14) $display("FAIL bp_reload got=%b/%0d exp=0010/14", out_valid, out_data[15:8]); else passed++;
    in_valid = 0;
    step();
    total++; if (out_valid !== 4'b0000) $display("FAIL bp_drain got=%b exp=0000", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      drive(2'd0, 8'(i), i == 7);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready beat%0d got=%b exp=1", i, in_ready); else passed++;
      step();
      total++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'(i) || out_last[0] !== (i == 7)) $display("FAIL b2b_beat%0d got=%b/%0d/%b exp=0001/%0d/%b", i, out_valid, out_data[7:0], out_last[0], i, i == 7); else passed++;
    end
    in_valid = 0;
    step();
    total++; if (out_valid !== 4'b0000 || pkt_active !== 1'b0) $display("FAIL b2b_end got=%b/%b exp=0000/0", out_valid, pkt_active); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 4'b0000;
    drive(2'd3, 8'h30, 1'b0);
    step();
    drive(2'd3, 8'h31, 1'b0);
    step();
    total++; if (pkt_active !== 1'b1 || cur_sel !== 2'd3 || out_valid !== 4'b1000) $display("FAIL mid_before got=%b/%0d/%b exp=1/3/1000", pkt_active, cur_sel, out_valid); else passed++;
    rst = 1;
    drive(2'd3, 8'h32, 1'b0);
    step();
    rst = 0;
    total++; if (pkt_active !== 1'b0 || out_valid !== 4'b0000) $display("FAIL mid_reset got=%b/%b exp=0/0000", pkt_active, out_valid); else passed++;
    drive(2'd1, 8'h55, 1'b1);
    step();
    total++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h55) $display("FAIL mid_reroute got=%b/%h exp=0010/55", out_valid, out_data[15:8]); else passed++;
    in_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_beats();
    test_packet_lock();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
